// File: rtl/fetch_pkg.sv
// Shared widths, constants and the queue entry type for the instruction-fetch stage.
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 8;
  localparam int FETCH_INSTR_W = 32;
  localparam int FETCH_DEPTH   = 4;

  localparam logic [FETCH_INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_INSTR_W-1:0] instr;
    logic [FETCH_ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO of fetch_entry_t with push, pop, clear, occupancy count
// and async active-high reset. Push and pop at full are both accepted.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               clear,
  input  fetch_entry_t       wr_entry,
  output fetch_entry_t       rd_entry,
  output logic [CNT_W-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop   = pop && (count != '0);
  assign do_push  = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign rd_entry = mem[rd_ptr];

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage is not reset; count gates every read, so stale words are never exposed.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: credit-based imem reads, tagged queue, valid/ready to decode.
// Optional same-cycle bypass of an empty queue via FETCH_QUEUE_BYPASS_EN.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = FETCH_ADDR_W,
  parameter int INSTR_W = FETCH_INSTR_W,
  parameter int DEPTH   = FETCH_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic               pc_stall,
  input  logic               flush,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              inflight;
  logic              kill;
  logic [ADDR_W-1:0] req_pc;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    occupied;
  logic              has_credit;
  logic              issue;
  logic              resp_valid;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  fetch_entry_t      rd_entry;
  fetch_entry_t      head;

  // Outstanding read counts against capacity so its response always has a slot.
  assign occupied   = {1'b0, fifo_count} + (CNT_W + 1)'(inflight);
  assign has_credit = occupied < (CNT_W + 1)'(DEPTH);
  assign issue      = has_credit && !flush;
  assign imem_req   = issue && !reset;
  assign imem_addr  = pc_in;
  assign pc_stall   = !has_credit && !flush && !reset;

  assign resp_valid = inflight && !kill && !flush;
  assign fifo_empty = (fifo_count == '0);
  assign pop        = out_ready && !fifo_empty;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    head      = rd_entry;
    out_valid = !fifo_empty;
    push      = resp_valid;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (resp_valid && fifo_empty) begin
      out_valid = 1'b1;
      head      = '{instr: imem_rdata, pc: req_pc};
      push      = !out_ready;
    end
`endif
  end

  assign out_instr = out_valid ? head.instr : '0;
  assign out_pc    = out_valid ? head.pc    : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= 1'b0;
      kill     <= 1'b0;
      req_pc   <= '0;
    end else begin
      inflight <= issue;
      kill     <= flush;
      if (issue) req_pc <= pc_in;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .clear    (flush),
    .wr_entry ('{instr: imem_rdata, pc: req_pc}),
    .rd_entry (rd_entry),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue with a PC-register and 1-cycle imem model.
module tb_fetch_queue;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk;
  logic        reset;
  logic [7:0]  pc_in;
  logic        pc_stall;
  logic        flush;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [7:0]  out_pc;

  logic [7:0]  pc_reset_val;
  logic [7:0]  flush_target;
  int          n_checks;
  int          n_pass;

  fetch_queue dut (
    .clk        (clk),
    .reset      (reset),
    .pc_in      (pc_in),
    .pc_stall   (pc_stall),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // PC register: holds while stalled, loads the redirect target on flush.
  always @(posedge clk or posedge reset) begin
    if (reset)         pc_in <= pc_reset_val;
    else if (flush)    pc_in <= flush_target;
    else if (imem_req) pc_in <= pc_in + 8'd4;
  end

  // Instruction memory: word at address a is C0DE_00aa, one cycle after the strobe.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? (32'hC0DE_0000 | {24'h0, imem_addr}) : 32'hDEAD_DEAD;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [7:0] rv);
    pc_reset_val = rv;
    out_ready    = 1'b0;
    flush        = 1'b0;
    reset        = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic check_entry(input string tag, input logic [7:0] pc);
    check({tag, "_valid"}, {31'h0, out_valid}, 32'd1);
    check({tag, "_pc"}, {24'h0, out_pc}, {24'h0, pc});
    check({tag, "_instr"}, out_instr, 32'hC0DE_0000 | {24'h0, pc});
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    reset        = 1'b0;
    flush        = 1'b0;
    out_ready    = 1'b0;
    pc_reset_val = 8'h00;
    flush_target = 8'h00;
    #1 reset = 1'b1;
    #1;
    check("rst_valid", {31'h0, out_valid}, 32'd0);
    check("rst_req",   {31'h0, imem_req},  32'd0);
    check("rst_stall", {31'h0, pc_stall},  32'd0);
    check("rst_instr", out_instr,          32'd0);
    check("rst_pc",    {24'h0, out_pc},    32'd0);

    // Streaming with decode always ready.
    do_reset(8'h00);
    out_ready = 1'b1;
    #1;
    check("str_req0",   {31'h0, imem_req},  32'd1);
    check("str_addr0",  {24'h0, imem_addr}, 32'h00);
    check("str_nvalid", {31'h0, out_valid}, 32'd0);
    for (int w = 1; w < LAT; w++) begin
      tick(); #1;
      check("str_lat", {31'h0, out_valid}, 32'd0);
    end
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      check_entry("str", 8'(4 * k));
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    check("byp_count", 32'(dut.u_fifo.count), 32'd0);
`endif

    // Backpressure: four requests fill the credit, then stall; drain across pointer wrap.
    do_reset(8'h00);
    for (int w = 0; w < 6; w++) begin
      if (w > 0) tick();
      #1;
      check("bp_req",   {31'h0, imem_req}, {31'h0, w < 4});
      check("bp_stall", {31'h0, pc_stall}, {31'h0, w >= 4});
      if (w < 4) check("bp_addr", {24'h0, imem_addr}, 32'(4 * w));
    end
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) tick();
      #1;
      check_entry("wrap", 8'(4 * k));
    end

    // Flush while the read of 0x10 is in flight.
    do_reset(8'h00);
    out_ready = 1'b1;
    for (int w = 1; w <= 4; w++) tick();
    #1;
    check("fl_req10",  {31'h0, imem_req},  32'd1);
    check("fl_addr10", {24'h0, imem_addr}, 32'h10);
    tick();
    flush_target = 8'h40;
    flush        = 1'b1;
    #1;
    check("fl_req",   {31'h0, imem_req}, 32'd0);
    check("fl_stall", {31'h0, pc_stall}, 32'd0);
    tick();
    flush = 1'b0;
    #1;
    check("fl_nvalid", {31'h0, out_valid}, 32'd0);
    check("fl_req40",  {31'h0, imem_req},  32'd1);
    check("fl_addr40", {24'h0, imem_addr}, 32'h40);
    for (int i = 0; i < 6 && !out_valid; i++) begin
      tick(); #1;
    end
    check_entry("fl_next", 8'h40);

    // Reset with three entries queued and a read in flight.
    do_reset(8'h00);
    for (int w = 1; w <= 4; w++) tick();
    #1;
    check("mr_stall_pre", {31'h0, pc_stall}, 32'd1);
    pc_reset_val = 8'h20;
    reset        = 1'b1;
    #1;
    check("mr_valid", {31'h0, out_valid}, 32'd0);
    check("mr_req",   {31'h0, imem_req},  32'd0);
    check("mr_stall", {31'h0, pc_stall},  32'd0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("mr_req1",   {31'h0, imem_req},  32'd1);
    check("mr_addr1",  {24'h0, imem_addr}, 32'h20);
    check("mr_nvalid", {31'h0, out_valid}, 32'd0);
    for (int w = 1; w < LAT; w++) begin
      tick(); #1;
      check("mr_lat", {31'h0, out_valid}, 32'd0);
    end
    tick(); #1;
    check_entry("mr_first", 8'h20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
